// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and amplitude helpers for the spectrum display writer.
package display_pkg;

    localparam int DISP_BINS    = 256;
    localparam int DISP_ADDR_W  = 8;
    localparam int DISP_AMP_W   = 9;
    localparam int DISP_AMP_MAX = 440;

    typedef enum logic [1:0] {
        INIT_CLEAR = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2,
        CLEAR      = 2'd3
    } disp_state_e;

    function automatic logic [DISP_AMP_W-1:0] decay_amp(
        input logic [DISP_AMP_W-1:0] held,
        input logic [DISP_AMP_W-1:0] step
    );
        if (held > step) begin
            return held - step;
        end else begin
            return {DISP_AMP_W{1'b0}};
        end
    endfunction

    function automatic logic [DISP_AMP_W-1:0] max_amp(
        input logic [DISP_AMP_W-1:0] a,
        input logic [DISP_AMP_W-1:0] b
    );
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/peak_hold_ram.sv
// 256x9 peak-hold shadow memory: one synchronous read port, one write port, no reset.
// A read and a write to the same address on the same edge return the old contents.
module peak_hold_ram
    import display_pkg::*;
(
    input  logic                   clk_i,
    input  logic [DISP_ADDR_W-1:0] rd_addr_i,
    output logic [DISP_AMP_W-1:0]  rd_data_o,
    input  logic                   wr_en_i,
    input  logic [DISP_ADDR_W-1:0] wr_addr_i,
    input  logic [DISP_AMP_W-1:0]  wr_data_i
);

    logic [DISP_AMP_W-1:0] mem_q [0:DISP_BINS-1];

    // Registered read and write of the shadow array
    always_ff @(posedge clk_i) begin
        rd_data_o <= mem_q[rd_addr_i];
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/spectrum_display_writer.sv
// Scales FFT magnitudes, applies peak-hold with linear decay and writes the display RAM.
// Sweep writes and beat writes share one registered write path that also feeds the shadow memory.
module spectrum_display_writer
    import display_pkg::*;
#(
    parameter int MAG_W   = 16,
    parameter int SHIFT   = 6,
    parameter int AMP_MAX = DISP_AMP_MAX,
    parameter int DECAY   = 4
) (
    input  logic                   clk_25m,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   mag_valid,
    output logic                   mag_ready,
    input  logic [DISP_ADDR_W-1:0] mag_bin,
    input  logic [MAG_W-1:0]       mag_data,
    input  logic                   mag_last,
    output logic                   wr_en,
    output logic [DISP_ADDR_W-1:0] wr_addr,
    output logic [DISP_AMP_W-1:0]  wr_data,
    output logic                   frame_done,
    output logic                   busy
);

    disp_state_e            state_q, state_d;
    logic [DISP_ADDR_W-1:0] sweep_q, sweep_d;
    logic                   mag_ready_q, mag_ready_d;
    logic                   busy_q, busy_d;

    logic                   s1_valid_q, s1_valid_d;
    logic [DISP_ADDR_W-1:0] s1_bin_q, s1_bin_d;
    logic [DISP_AMP_W-1:0]  s1_scaled_q, s1_scaled_d;
    logic                   s1_last_q, s1_last_d;

    logic                   wr_en_q, wr_en_d;
    logic [DISP_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DISP_AMP_W-1:0]  wr_data_q, wr_data_d;
    logic                   frame_done_q, frame_done_d;

    logic                   fw2_valid_q;
    logic [DISP_ADDR_W-1:0] fw2_addr_q;
    logic [DISP_AMP_W-1:0]  fw2_data_q;

    logic                   accept_s;
    logic [MAG_W-1:0]       shifted_s;
    logic [DISP_AMP_W-1:0]  scaled_s;
    logic [DISP_AMP_W-1:0]  rd_data_s;
    logic [DISP_AMP_W-1:0]  held_s;
    logic [DISP_AMP_W-1:0]  new_s;

    peak_hold_ram u_hold (
        .clk_i     (clk_25m),
        .rd_addr_i (mag_bin),
        .rd_data_o (rd_data_s),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (wr_data_q)
    );

    // Saturating scale at accept time; the full-width shift result is compared so nothing is lost
    always_comb begin
        shifted_s = mag_data >> SHIFT;
        if (shifted_s > MAG_W'(AMP_MAX)) begin
            scaled_s = DISP_AMP_W'(AMP_MAX);
        end else begin
            scaled_s = shifted_s[DISP_AMP_W-1:0];
        end
    end

    // The write register is one beat ahead, its delayed copy two ahead (memory read missed it)
    always_comb begin
        if (wr_en_q && (wr_addr_q == s1_bin_q)) begin
            held_s = wr_data_q;
        end else if (fw2_valid_q && (fw2_addr_q == s1_bin_q)) begin
            held_s = fw2_data_q;
        end else begin
            held_s = rd_data_s;
        end
        new_s = max_amp(s1_scaled_q, decay_amp(held_s, DISP_AMP_W'(DECAY)));
    end

    // Control FSM, beat pipeline and the shared write path
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        accept_s     = mag_valid & mag_ready_q;
        s1_valid_d   = accept_s;
        s1_bin_d     = s1_bin_q;
        s1_scaled_d  = s1_scaled_q;
        s1_last_d    = s1_last_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        if (accept_s) begin
            s1_bin_d    = mag_bin;
            s1_scaled_d = scaled_s;
            s1_last_d   = mag_last;
        end else begin
            s1_last_d   = 1'b0;
        end

        case (state_q)
            INIT_CLEAR, CLEAR: begin
                if (clear) begin
                    sweep_d = {DISP_ADDR_W{1'b0}};
                end else if (sweep_q == 8'd255) begin
                    sweep_d = {DISP_ADDR_W{1'b0}};
                    state_d = RUN;
                end else begin
                    sweep_d = sweep_q + 8'd1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                sweep_d = {DISP_ADDR_W{1'b0}};
                if (!s1_valid_q) begin
                    state_d = CLEAR;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = INIT_CLEAR;
                sweep_d = {DISP_ADDR_W{1'b0}};
            end
        endcase

        if (s1_valid_q) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = s1_bin_q;
            wr_data_d    = new_s;
            frame_done_d = s1_last_q;
        end else if ((state_q == INIT_CLEAR) || (state_q == CLEAR)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sweep_q;
            wr_data_d = {DISP_AMP_W{1'b0}};
        end else begin
            wr_en_d = 1'b0;
        end

        mag_ready_d = (state_q == RUN) && !clear;
        busy_d      = !mag_ready_d;
    end

    // State and pipeline registers
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_CLEAR;
            sweep_q      <= {DISP_ADDR_W{1'b0}};
            mag_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_bin_q     <= {DISP_ADDR_W{1'b0}};
            s1_scaled_q  <= {DISP_AMP_W{1'b0}};
            s1_last_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {DISP_ADDR_W{1'b0}};
            wr_data_q    <= {DISP_AMP_W{1'b0}};
            frame_done_q <= 1'b0;
            fw2_valid_q  <= 1'b0;
            fw2_addr_q   <= {DISP_ADDR_W{1'b0}};
            fw2_data_q   <= {DISP_AMP_W{1'b0}};
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            mag_ready_q  <= mag_ready_d;
            busy_q       <= busy_d;
            s1_valid_q   <= s1_valid_d;
            s1_bin_q     <= s1_bin_d;
            s1_scaled_q  <= s1_scaled_d;
            s1_last_q    <= s1_last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            fw2_valid_q  <= wr_en_q;
            fw2_addr_q   <= wr_addr_q;
            fw2_data_q   <= wr_data_q;
        end
    end

    assign mag_ready  = mag_ready_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spectrum_display_writer.sv
// Randomised bench for spectrum_display_writer: a queue-based reference model predicts
// every display write (address, amplitude, frame marker, latency) from the accepted beats.
module tb_spectrum_display_writer;

    logic        clk_25m = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        mag_valid = 1'b0;
    logic        mag_ready;
    logic [7:0]  mag_bin = 8'd0;
    logic [15:0] mag_data = 16'd0;
    logic        mag_last = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        frame_done;
    logic        busy;

    spectrum_display_writer dut (
        .clk_25m    (clk_25m),
        .rst        (rst),
        .clear      (clear),
        .mag_valid  (mag_valid),
        .mag_ready  (mag_ready),
        .mag_bin    (mag_bin),
        .mag_data   (mag_data),
        .mag_last   (mag_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #20 clk_25m = ~clk_25m;

    typedef struct {
        int addr;
        int data;
        bit last;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  held[256];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  sweep_pending = 1'b0;
    int  last_data = -1;
    int  hist[3];
    int  fd_count = 0;
    int  fd_addr = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_sweep();
        wr_t e;
        for (int a = 0; a < 256; a++) begin
            e.addr = a; e.data = 0; e.last = 1'b0; e.cyc = 0;
            exp_q.push_back(e);
            held[a] = 0;
        end
    endfunction

    // Reference model and write checker, sampled mid low phase
    always begin
        wr_t e;
        int  sc;
        int  dc;
        @(negedge clk_25m);
        #2;
        cyc++;
        if (rst) begin
            exp_q.delete();
            sweep_pending = 1'b1;
        end else begin
            if (sweep_pending) begin
                push_sweep();
                sweep_pending = 1'b0;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("wr_addr", 32'(wr_addr), e.addr);
                    check_val("wr_data", 32'(wr_data), e.data);
                    check_val("frame_done", 32'(frame_done), 32'(e.last));
                    if (e.cyc != 0) check_val("wr_latency", cyc, e.cyc);
                end
                last_data = int'(wr_data);
                hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = int'(wr_data);
            end else if (frame_done) begin
                check_val("frame_done_idle", 32'd1, 32'd0);
            end
            if (frame_done) begin
                fd_count++;
                fd_addr = int'(wr_addr);
            end
            if (mag_valid && mag_ready) begin
                sc = int'(mag_data) / 64;
                if (sc > 440) sc = 440;
                dc = (held[mag_bin] > 4) ? held[mag_bin] - 4 : 0;
                e.addr = int'(mag_bin);
                e.data = (sc > dc) ? sc : dc;
                e.last = mag_last;
                e.cyc  = cyc + 2;
                held[mag_bin] = e.data;
                exp_q.push_back(e);
            end
            if (clear && mag_ready) begin
                push_sweep();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_25m);
        #1;
    endtask

    task automatic put_beat(input int b, input int d, input bit l, input bit clr);
        int n;
        mag_valid = 1'b1;
        mag_bin   = b[7:0];
        mag_data  = d[15:0];
        mag_last  = l;
        n = 0;
        @(negedge clk_25m);
        while (!mag_ready && n < 2000) begin
            @(negedge clk_25m);
            n++;
        end
        if (!mag_ready) check_val("accept_timeout", 32'd0, 32'd1);
        #1;
        clear = clr;
        @(posedge clk_25m);
        #1;
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic beat_expect(input string tag, input int b, input int d, input int exp);
        put_beat(b, d, 1'b1, 1'b0);
        idle(3);
        check_val(tag, last_data, exp);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_25m);
        check_val("rst_mag_ready", 32'(mag_ready), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd1);
        @(posedge clk_25m);
        #1;
        rst = 1'b0;

        // Initial 256-cycle zero sweep
        @(negedge clk_25m);
        check_val("pre_sweep_wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_25m);
            check_val("sweep_wr_en", 32'(wr_en), 32'd1);
            check_val("sweep_addr", 32'(wr_addr), i);
            check_val("sweep_busy", 32'(busy), 32'd1);
            check_val("sweep_ready", 32'(mag_ready), 32'd0);
        end
        @(negedge clk_25m);
        check_val("post_sweep_wr_en", 32'(wr_en), 32'd0);
        check_val("post_sweep_ready", 32'(mag_ready), 32'd1);
        check_val("post_sweep_busy", 32'(busy), 32'd0);
        @(posedge clk_25m);
        #1;

        // Scaling, saturation and decay
        beat_expect("scale_64", 10, 16'h1000, 64);
        beat_expect("saturate_440", 10, 16'hFFFF, 440);
        beat_expect("decay_436", 10, 0, 436);
        beat_expect("decay_432", 10, 0, 432);
        beat_expect("decay_428", 10, 0, 428);
        beat_expect("hold_3", 20, 3 * 64, 3);
        beat_expect("decay_floor_0", 20, 0, 0);

        // Back-to-back same-bin forwarding
        put_beat(5, 16'h2000, 1'b0, 1'b0);
        put_beat(5, 0, 1'b0, 1'b0);
        put_beat(5, 0, 1'b0, 1'b0);
        idle(4);
        check_val("fwd_0", hist[0], 128);
        check_val("fwd_1", hist[1], 124);
        check_val("fwd_2", hist[2], 120);

        // Full continuous frame
        fd_count = 0;
        for (int b = 0; b < 256; b++) put_beat(b, $urandom_range(0, 65535), b == 255, 1'b0);
        idle(4);
        check_val("frame_done_count", fd_count, 1);
        check_val("frame_done_addr", fd_addr, 255);

        // Clear mid-frame, accepted together with bin 100
        for (int b = 0; b < 256; b++) begin
            put_beat(b, $urandom_range(0, 65535), b == 255, b == 100);
            if (b == 100) begin
                @(negedge clk_25m);
                check_val("drain_ready_low", 32'(mag_ready), 32'd0);
                check_val("drain_busy", 32'(busy), 32'd1);
            end
        end
        idle(4);

        // Random traffic over a few bins to stress forwarding
        for (int i = 0; i < 400; i++) begin
            put_beat($urandom_range(0, 7), $urandom_range(0, 65535),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        // Reset in the middle of a burst aborts in-flight beats
        put_beat(3, 16'h3000, 1'b0, 1'b0);
        put_beat(4, 16'h3000, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk_25m);
        check_val("midrst_wr_en", 32'(wr_en), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd1);
        @(posedge clk_25m);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) put_beat($urandom_range(0, 3), $urandom_range(0, 65535), 1'b0, 1'b0);
        idle(6);
        check_val("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spectrum_display_writer.md
Name: spectrum_display_writer

Overview:
- Upstream feeder of the dual-port display RAM, in the clk_25m domain.
- Accepts the FFT magnitude stream (one beat per bin) and scales each magnitude to the 0-440 amplitude range.
- Applies peak-hold with linear decay and drives the display RAM write port (wr_en/wr_addr/wr_data).
- Keeps its own peak-hold shadow memory, because the display RAM write port is write-only from this domain.

Parameters:
- MAG_W, 16, width of input magnitude.
- SHIFT, 6, right-shift applied to magnitude before saturation.
- AMP_MAX, 440, saturation ceiling of the scaled amplitude (fits 9 bits).
- DECAY, 4, amount subtracted from the held value per frame update.

Ports:
- clk_25m  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  one-cycle request to zero both hold memory and display.
- mag_valid  in  1  magnitude beat valid.
- mag_ready  out  1  block can accept a beat this cycle.
- mag_bin  in  8  bin index 0-255.
- mag_data  in  MAG_W  unsigned magnitude.
- mag_last  in  1  final beat of an FFT frame.
- wr_en  out  1  display RAM write strobe.
- wr_addr  out  8  display RAM address.
- wr_data  out  9  display RAM amplitude.
- frame_done  out  1  one-cycle pulse when the last beat's write issues.
- busy  out  1  high while a clear sweep or drain is in progress.

Behaviour:
- Reset values: mag_ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=1. FSM enters INIT_CLEAR.
- The hold memory has no reset. Correctness after reset depends on the sweep.
- FSM states:
  - INIT_CLEAR / CLEAR: sweep addr 0..255, one per cycle, writing 0 to hold memory and the display (wr_en=1, wr_data=0). Exactly 256 cycles; mag_ready=0, busy=1. After addr 255, go to RUN.
  - RUN: mag_ready=1, busy=0.
  - DRAIN: entered when clear=1 in RUN. mag_ready=0 from the next cycle. In-flight beats, at most 2, complete their writes, then go to CLEAR.
- clear is also accepted in INIT_CLEAR/CLEAR; it restarts the sweep from address 0.
- A beat is accepted on mag_valid & mag_ready. Beats not accepted must be held stable by the source. Frame beats stalled by a clear continue after the sweep.
- Pipeline for a beat accepted at cycle T:
  - T: hold-memory read issued at mag_bin.
  - T+1: compute.
    - scaled = min(mag_data >> SHIFT, AMP_MAX).
    - decayed = (held > DECAY) ? held - DECAY : 0.
    - new = max(scaled, decayed).
  - T+2: wr_en=1, wr_addr=bin, wr_data=new (registered). Hold memory is written with new in the same cycle.
- Throughput is one beat per cycle, with no bubbles.
- Forwarding: if a beat's bin matches a beat still in flight (1 or 2 ahead), use the in-flight new value instead of the stale memory value. Back-to-back same-bin beats must see sequential decay/max.
- frame_done=1 in the same cycle as the write of the beat that carried mag_last.
- Arithmetic is unsigned throughout. The shift result is at least 10 bits before saturation, so no truncation occurs pre-compare.
- wr_en=0 on every cycle with no write; wr_addr/wr_data hold their last values.
- Reset asserted mid-operation aborts in-flight beats and restarts INIT_CLEAR; no partial write is issued.

Decomposition:
- Package display_pkg:
  - DISP_BINS=256, DISP_ADDR_W=8, DISP_AMP_W=9, DISP_AMP_MAX=440.
  - FSM state encoding (INIT_CLEAR, RUN, DRAIN, CLEAR).
- Sub-module peak_hold_ram: single-clock 256x9 memory with one synchronous read port and one write port, 1-cycle read latency, no reset. Forwarding logic stays in the parent.

Test Plan:
- Reset release -> 256 consecutive wr_en cycles, wr_addr 0..255, wr_data=0, busy=1. Then mag_ready=1, busy=0 on the next cycle.
- Beat bin=10, mag_data=0x1000 (>>6 =64) -> two cycles later wr_addr=10, wr_data=64. Then bin=10, mag_data=0xFFFF (1023) -> wr_data=440 (saturated).
- After bin 10 holds 440, send bin=10 with mag_data=0 three times (separate frames) -> wr_data 436, 432, 428. A held value of 3 with zero input -> 0.
- Back-to-back beats bin=5 (mag 0x2000=128), then bin=5 (mag 0), then bin=5 (mag 0) on consecutive cycles -> writes 128, 124, 120 (forwarding verified).
- Full frame bins 0..255 streaming continuously, mag_last on bin 255 -> 256 consecutive writes, frame_done pulses exactly once, coincident with wr_addr=255.
- clear asserted after bin 100 is accepted mid-frame -> bins 99/100 written, mag_ready low, 256-cycle zero sweep, then frame resumes at bin 101 with held values 0-based.
